// File: rtl/pop_return_merger.sv
// Returns per-lane pop results on one port, in request order,
// tagged with the tree_id of the pop that produced them.
module pop_return_merger #(
  parameter int PTW           = 16,
  parameter int MTW           = 0,
  parameter int LEVEL         = 4,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int LEVEL_BITS    = $clog2(LEVEL),
  parameter int TAG_DEPTH     = 8,
  parameter int LANE_DEPTH    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pop,
  input  logic [TREE_NUM_BITS-1:0]     i_tree_id,
  input  logic [LEVEL*(MTW+PTW)-1:0]   i_lane_pop_data,
  input  logic [LEVEL-1:0]             i_lane_pop_valid,
  output logic                         o_req_full,
  output logic [MTW+PTW-1:0]           o_pop_data,
  output logic                         o_pop_data_valid,
  output logic [TREE_NUM_BITS-1:0]     o_pop_tree_id,
  output logic                         o_lane_overflow,
  output logic                         o_unexpected
);

  localparam int DW  = MTW + PTW;
  localparam int TPW = $clog2(TAG_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int LPW = $clog2(LANE_DEPTH);
  localparam int LCW = LPW + 1;

  localparam logic [TCW-1:0] TAG_FULL  = TCW'(TAG_DEPTH);
  localparam logic [LCW-1:0] LANE_FULL = LCW'(LANE_DEPTH);

  logic [TREE_NUM_BITS-1:0] tag_mem_q [TAG_DEPTH];
  logic [TPW-1:0]           tag_wr_q;
  logic [TPW-1:0]           tag_rd_q;
  logic [TCW-1:0]           tag_cnt_q;
  logic [TCW-1:0]           tag_cnt_d;
  logic                     req_full_q;

  logic [TCW-1:0] outst_q [LEVEL];
  logic [TCW-1:0] outst_d [LEVEL];

  logic [DW-1:0]  lane_mem_q [LEVEL][LANE_DEPTH];
  logic [LPW-1:0] lane_wr_q  [LEVEL];
  logic [LPW-1:0] lane_rd_q  [LEVEL];
  logic [LCW-1:0] lane_cnt_q [LEVEL];
  logic [LCW-1:0] lane_cnt_d [LEVEL];

  logic [LEVEL-1:0] lane_wr;
  logic [LEVEL-1:0] lane_rd;
  logic [LEVEL-1:0] lane_unexp;
  logic [LEVEL-1:0] lane_ovf;

  logic                     accept;
  logic                     retire;
  logic [TREE_NUM_BITS-1:0] head_tag;
  logic [LEVEL_BITS-1:0]    head_lane;
  logic [LEVEL_BITS-1:0]    req_lane;

  logic [DW-1:0]            pop_data_q;
  logic                     pop_valid_q;
  logic [TREE_NUM_BITS-1:0] pop_id_q;
  logic                     ovf_q;
  logic                     unexp_q;

  always_comb begin
    accept    = i_pop && !req_full_q;
    req_lane  = i_tree_id[LEVEL_BITS-1:0];
    head_tag  = tag_mem_q[tag_rd_q];
    head_lane = head_tag[LEVEL_BITS-1:0];
    retire    = (tag_cnt_q != '0) &&
                (lane_cnt_q[head_lane] != '0);
    tag_cnt_d = tag_cnt_q + TCW'(accept) - TCW'(retire);
    lane_wr    = '0;
    lane_rd    = '0;
    lane_unexp = '0;
    lane_ovf   = '0;
    for (int k = 0; k < LEVEL; k++) begin
      lane_rd[k] = retire &&
                   (head_lane == LEVEL_BITS'(k));
      lane_unexp[k] = i_lane_pop_valid[k] &&
                      (outst_q[k] == '0);
      // a read in the same cycle frees the slot
      lane_ovf[k] = i_lane_pop_valid[k] &&
                    (outst_q[k] != '0) &&
                    (lane_cnt_q[k] == LANE_FULL) &&
                    !lane_rd[k];
      lane_wr[k] = i_lane_pop_valid[k] &&
                   (outst_q[k] != '0) &&
                   !lane_ovf[k];
      outst_d[k] = outst_q[k]
        + TCW'(accept && (req_lane == LEVEL_BITS'(k)))
        - TCW'(i_lane_pop_valid[k] && (outst_q[k] != '0));
      lane_cnt_d[k] = lane_cnt_q[k]
        + LCW'(lane_wr[k]) - LCW'(lane_rd[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      tag_cnt_q   <= '0;
      req_full_q  <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      pop_id_q    <= '0;
      ovf_q       <= 1'b0;
      unexp_q     <= 1'b0;
      for (int k = 0; k < LEVEL; k++) begin
        outst_q[k]    <= '0;
        lane_wr_q[k]  <= '0;
        lane_rd_q[k]  <= '0;
        lane_cnt_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        tag_mem_q[tag_wr_q] <= i_tree_id;
        tag_wr_q <= tag_wr_q + 1'b1;
      end
      if (retire) begin
        tag_rd_q   <= tag_rd_q + 1'b1;
        pop_data_q <= lane_mem_q[head_lane][lane_rd_q[head_lane]];
        pop_id_q   <= head_tag;
      end
      pop_valid_q <= retire;
      tag_cnt_q   <= tag_cnt_d;
      req_full_q  <= (tag_cnt_d == TAG_FULL);
      ovf_q       <= ovf_q | (|lane_ovf);
      unexp_q     <= unexp_q | (|lane_unexp);
      for (int k = 0; k < LEVEL; k++) begin
        outst_q[k]    <= outst_d[k];
        lane_cnt_q[k] <= lane_cnt_d[k];
        if (lane_wr[k]) begin
          lane_mem_q[k][lane_wr_q[k]] <=
            i_lane_pop_data[k*DW +: DW];
          lane_wr_q[k] <= lane_wr_q[k] + 1'b1;
        end
        if (lane_rd[k]) begin
          lane_rd_q[k] <= lane_rd_q[k] + 1'b1;
        end
      end
    end
  end

  assign o_req_full       = req_full_q;
  assign o_pop_data       = pop_data_q;
  assign o_pop_data_valid = pop_valid_q;
  assign o_pop_tree_id    = pop_id_q;
  assign o_lane_overflow  = ovf_q;
  assign o_unexpected     = unexp_q;

endmodule

// File: tb/tb_pop_return_merger.sv
// Directed bench for pop_return_merger: ordering, latency,
// full/overflow/unexpected handling and mid-stream reset.
module tb_pop_return_merger;

  localparam int PTW = 16;
  localparam int LEVEL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pop;
  logic [1:0]        tree_id;
  logic [LEVEL*PTW-1:0] lane_data;
  logic [LEVEL-1:0]  lane_valid;
  logic              req_full;
  logic [PTW-1:0]    pop_data;
  logic              pop_valid;
  logic [1:0]        pop_id;
  logic              lane_ovf;
  logic              unexp;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mon_q[$];

  pop_return_merger dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pop            (pop),
    .i_tree_id        (tree_id),
    .i_lane_pop_data  (lane_data),
    .i_lane_pop_valid (lane_valid),
    .o_req_full       (req_full),
    .o_pop_data       (pop_data),
    .o_pop_data_valid (pop_valid),
    .o_pop_tree_id    (pop_id),
    .o_lane_overflow  (lane_ovf),
    .o_unexpected     (unexp)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (pop_valid) mon_q.push_back({14'd0, pop_id, pop_data});

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pop = 1'b0;
    lane_valid = '0;
  endtask

  task automatic do_pop(input logic [1:0] id);
    pop = 1'b1;
    tree_id = id;
    tick();
  endtask

  task automatic strobe(input int k, input logic [15:0] d);
    lane_valid[k] = 1'b1;
    lane_data[k*PTW +: PTW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pk(input logic [1:0] id,
                                     input logic [15:0] d);
    return {14'd0, id, d};
  endfunction

  initial begin
    rst = 1'b1;
    pop = 1'b0;
    tree_id = '0;
    lane_data = '0;
    lane_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data",  32'(pop_data),  32'h0);
    check("rst_valid", 32'(pop_valid), 32'h0);
    check("rst_id",    32'(pop_id),    32'h0);
    check("rst_full",  32'(req_full),  32'h0);
    check("rst_ovf",   32'(lane_ovf),  32'h0);
    check("rst_unexp", 32'(unexp),     32'h0);

    // single pop, two-cycle latency from lane strobe
    do_pop(2'd2);
    tick();
    strobe(2, 16'h00A5);
    tick();
    check("lat_n1_valid", 32'(pop_valid), 32'h0);
    tick();
    check("lat_n2_valid", 32'(pop_valid), 32'h1);
    check("lat_data", 32'(pop_data), 32'h00A5);
    check("lat_id",   32'(pop_id),   32'h2);
    tick();
    check("lat_n3_valid", 32'(pop_valid), 32'h0);

    // out-of-order lane return, in-order output
    mon_q.delete();
    do_pop(2'd0);
    do_pop(2'd1);
    strobe(1, 16'h0011);
    tick();
    tick();
    check("ooo_wait_valid", 32'(pop_valid), 32'h0);
    strobe(0, 16'h0022);
    tick();
    tick();
    check("ooo_first", {14'd0, pop_id, pop_data}, pk(0, 16'h0022));
    tick();
    check("ooo_second", {14'd0, pop_id, pop_data}, pk(1, 16'h0011));
    check("ooo_second_v", 32'(pop_valid), 32'h1);
    tick();
    check("ooo_count", 32'(mon_q.size()), 32'd2);

    // fill tag FIFO, ninth pop ignored
    mon_q.delete();
    for (int i = 0; i < 8; i++) begin
      check("fill_notfull", 32'(req_full), 32'h0);
      do_pop(2'(i));
    end
    check("full_set", 32'(req_full), 32'h1);
    do_pop(2'd0);
    check("full_9th", 32'(req_full), 32'h1);
    for (int k = 0; k < 4; k++) strobe(k, 16'h0300 + 16'(k));
    tick();
    for (int k = 0; k < 4; k++) strobe(k, 16'h0310 + 16'(k));
    tick();
    check("full_first_v",   32'(pop_valid), 32'h1);
    check("full_clr_retire", 32'(req_full), 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("full_count", 32'(mon_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++)
      check($sformatf("full_seq%0d", i), mon_q[i],
            pk(2'(i % 4), 16'h0300 + 16'((i / 4) * 16 + i % 4)));

    // result with nothing outstanding
    mon_q.delete();
    strobe(3, 16'h0BAD);
    tick();
    check("unexp_set", 32'(unexp), 32'h1);
    tick();
    check("unexp_novalid", 32'(pop_valid), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("unexp_sticky", 32'(unexp), 32'h1);
    check("unexp_noout", 32'(mon_q.size()), 32'd0);

    do_reset();
    check("rst2_unexp", 32'(unexp), 32'h0);

    // lane-0 overflow behind a stalled tree-1 head
    mon_q.delete();
    do_pop(2'd1);
    do_pop(2'd0);
    do_pop(2'd0);
    do_pop(2'd0);
    strobe(0, 16'h0501);
    tick();
    strobe(0, 16'h0502);
    tick();
    check("ovf_clear", 32'(lane_ovf), 32'h0);
    strobe(0, 16'h0503);
    tick();
    check("ovf_set", 32'(lane_ovf), 32'h1);
    check("ovf_novalid", 32'(pop_valid), 32'h0);
    strobe(1, 16'h05AA);
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("ovf_count", 32'(mon_q.size()), 32'd3);
    if (mon_q.size() >= 3) begin
      check("ovf_seq0", mon_q[0], pk(1, 16'h05AA));
      check("ovf_seq1", mon_q[1], pk(0, 16'h0501));
      check("ovf_seq2", mon_q[2], pk(0, 16'h0502));
    end
    check("ovf_nounexp", 32'(unexp), 32'h0);

    // reset mid-stream with tags and buffered results
    do_reset();
    mon_q.delete();
    do_pop(2'd1);
    do_pop(2'd0);
    do_pop(2'd0);
    do_pop(2'd2);
    strobe(0, 16'h0601);
    tick();
    strobe(0, 16'h0602);
    tick();
    rst = 1'b1;
    pop = 1'b1;
    tree_id = 2'd1;
    tick();
    rst = 1'b0;
    check("mid_data",  32'(pop_data),  32'h0);
    check("mid_valid", 32'(pop_valid), 32'h0);
    check("mid_id",    32'(pop_id),    32'h0);
    check("mid_full",  32'(req_full),  32'h0);
    check("mid_ovf",   32'(lane_ovf),  32'h0);
    check("mid_unexp", 32'(unexp),     32'h0);
    strobe(1, 16'h0701);
    tick();
    check("mid_late_unexp", 32'(unexp), 32'h1);
    strobe(0, 16'h0702);
    tick();
    tick();
    tick();
    check("mid_noout", 32'(mon_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pop_return_merger.md
Name: pop_return_merger

Overview:
- Response-side counterpart of the per-root push/pop request demux in front of the PIFO SRAM top.
- Collects pop results from the LEVEL per-root RPU lanes and returns them on the single external pop-data port.
- Results are returned strictly in the order the pop requests were issued, tagged with the requesting tree_id.
- Absorbs out-of-order lane latency with a request-order tag FIFO and small per-lane response buffers.

Parameters:
PTW, 16, payload width
MTW, 0, metadata width
LEVEL, 4, number of lanes (root RPUs)
TREE_NUM, 4, number of trees
TREE_NUM_BITS, $clog2(TREE_NUM), tree_id width
LEVEL_BITS, $clog2(LEVEL), lane index width
TAG_DEPTH, 8, outstanding-pop order FIFO depth (power of 2)
LANE_DEPTH, 2, per-lane response buffer depth (power of 2)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_pop  input  1  pop request issued to the tree fabric this cycle
i_tree_id  input  TREE_NUM_BITS  tree of the pop request
i_lane_pop_data  input  LEVEL*(MTW+PTW)  flattened lane results; lane k at bits [k*(MTW+PTW) +: MTW+PTW]
i_lane_pop_valid  input  LEVEL  per-lane one-cycle result strobe
o_req_full  output  1  tag FIFO full; a pop issued while high is not tracked
o_pop_data  output  MTW+PTW  returned result
o_pop_data_valid  output  1  one-cycle strobe for o_pop_data
o_pop_tree_id  output  TREE_NUM_BITS  tree_id of the returned result
o_lane_overflow  output  1  sticky: a result arrived at a full lane buffer
o_unexpected  output  1  sticky: a result arrived on a lane with no outstanding request

Behaviour:
- Reset (i_rst high at a clock edge):
  - Empties the tag FIFO and all lane buffers; clears all outstanding counters.
  - All outputs go to 0. Sticky flags are cleared.
  - Requests and results presented during reset are discarded.
- Lane of a request: lane = i_tree_id[LEVEL_BITS-1:0], i.e. tree_id mod LEVEL.
- Request acceptance:
  - Condition: i_pop && !o_req_full.
  - Action: enqueue i_tree_id into the tag FIFO; increment outstanding[lane].
  - o_req_full is registered: high when tag count == TAG_DEPTH.
  - A request while full is ignored, even if a retire occurs in the same cycle.
- Lane result capture, for each k with i_lane_pop_valid[k]:
  - If outstanding[k] == 0 (value before this cycle's update): drop the result, set o_unexpected.
  - Else, if lane buffer k is full and not being read this cycle: drop the result, set o_lane_overflow; outstanding[k] is still decremented.
  - Else: write the result into buffer k; decrement outstanding[k].
  - A result never belongs to a request accepted in the same cycle.
  - Multiple lanes may strobe in the same cycle; each is handled independently.
- Retire:
  - Condition: tag FIFO non-empty and the lane buffer selected by the head tag is non-empty.
  - Action, in the same cycle:
    - Dequeue the head tag and read one entry from that lane buffer.
    - Next edge: o_pop_data <= buffer entry, o_pop_tree_id <= head tag, o_pop_data_valid <= 1.
  - Otherwise o_pop_data_valid <= 0, and o_pop_data / o_pop_tree_id hold their last values.
  - At most one retire per cycle.
- Ordering:
  - A result whose tag is not at the head waits in its lane buffer until all earlier requests have retired, regardless of lane arrival order.
- Latency:
  - A lane strobe in cycle n, with its tag at the head and nothing else pending, gives o_pop_data_valid high in cycle n+2.
  - A newly accepted tag cannot retire in its acceptance cycle (no bypass).
- Simultaneous events:
  - Tag enqueue and dequeue in one cycle: count unchanged.
  - Lane buffer write and read in one cycle: allowed at any occupancy, including full.
- Pointers wrap modulo depth. Counters are sized to hold TAG_DEPTH.

Test Plan:
- Reset, then pop tree 2, lane 2 strobes data 0x00A5 two cycles later → o_pop_data_valid high exactly 2 cycles after the strobe; o_pop_data = 0x00A5; o_pop_tree_id = 2.
- Pops to trees 0 then 1; lane 1 returns 0x0011 before lane 0 returns 0x0022 → outputs in order 0x0022 (id 0) then 0x0011 (id 1), on consecutive cycles after the lane-0 strobe.
- Issue 8 pops with no results → o_req_full high; 9th pop ignored; deliver 8 results → exactly 8 output strobes; o_req_full low after the first retire.
- Lane 3 strobe with no outstanding request → o_unexpected = 1, no output strobe; flag holds until i_rst.
- 3 pops to tree 0 while head tag is for tree 1 (still unanswered); lane 0 returns 3 results → third dropped, o_lane_overflow = 1; tree 1 result then releases 2 lane-0 results.
- Assert i_rst mid-stream with 4 tags outstanding and 2 results buffered → all outputs 0 the next cycle; later lane strobes flag o_unexpected.
